// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN datapath.
// State encoding plus rounding/saturation helpers.
package cnn_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   function automatic int clog2c(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic logic signed [63:0] round_shift(
      input logic signed [63:0] v,
      input logic [4:0]         sh
   );
      logic signed [63:0] t;
      if (sh == 5'd0) return v;
      t = v + (64'sd1 <<< (sh - 5'd1));
      return t >>> sh;
   endfunction

   function automatic logic signed [63:0] sat_dw(
      input logic signed [63:0] v,
      input int                 dw
   );
      logic signed [63:0] mx;
      logic signed [63:0] mn;
      mx = (64'sd1 <<< (dw - 1)) - 64'sd1;
      mn = -(64'sd1 <<< (dw - 1));
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

endpackage

// File: rtl/mac_lane_tree.sv
// Lane multipliers and adder tree, two register stages.
// A side-band tag travels alongside the data.
module mac_lane_tree
   import cnn_pkg::*;
#(
   parameter int LANES = 4,
   parameter int DW    = 16,
   parameter int TW    = 4,
   localparam int PW   = 2 * DW,
   localparam int SW   = PW + clog2c(LANES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_en,
   input  logic [TW-1:0]        i_tag,
   input  logic [LANES*DW-1:0]  i_ifm,
   input  logic [LANES*DW-1:0]  i_w,
   output logic signed [SW-1:0] o_sum,
   output logic [TW-1:0]        o_tag
);

   logic signed [PW-1:0] r_prod [LANES];
   logic [TW-1:0]        r_tag1;
   logic [TW-1:0]        r_tag2;
   logic signed [SW-1:0] r_sum;
   logic signed [SW-1:0] w_sum;

   // S1: one signed product per lane
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
         r_tag1 <= '0;
      end else if (i_en) begin
         for (int i = 0; i < LANES; i++)
            r_prod[i] <= PW'(signed'(i_ifm[(LANES-1-i)*DW +: DW]))
                       * PW'(signed'(i_w[(LANES-1-i)*DW +: DW]));
         r_tag1 <= i_tag;
      end
   end

   // adder tree over the lane products
   always_comb begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) w_sum = w_sum + SW'(r_prod[i]);
   end

   // S2: registered beat sum
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum  <= '0;
         r_tag2 <= '0;
      end else if (i_en) begin
         r_sum  <= w_sum;
         r_tag2 <= r_tag1;
      end
   end

   assign o_sum = r_sum;
   assign o_tag = r_tag2;

endmodule

// File: rtl/mac_acc_engine.sv
// Dot-product MAC with round/shift/ReLU/saturate and packing.
// Job control FSM plus valid/ready on input and output.
module mac_acc_engine
   import cnn_pkg::*;
#(
   parameter int LANES = 4,
   parameter int DW    = 16,
   parameter int PACK  = 4,
   parameter int LEN_W = 10,
   parameter int AW    = 44
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [LEN_W-1:0]    cfg_len,
   input  logic [LEN_W-1:0]    cfg_neurons,
   input  logic [4:0]          cfg_shift,
   input  logic                cfg_relu,
   output logic                busy,
   output logic                done,
   output logic                err,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [LANES*DW-1:0] in_ifm,
   input  logic [LANES*DW-1:0] in_w,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PACK*DW-1:0]  out_data,
   output logic                out_last
);

   localparam int SW = 2 * DW + clog2c(LANES);
   localparam int TW = 4;
   localparam int IW = (PACK > 1) ? clog2c(PACK) : 1;

   state_t r_state, w_state_nxt;

   logic [LEN_W-1:0]     r_len, r_neurons, r_beat, r_neur;
   logic [4:0]           r_shift;
   logic                 r_relu, r_err;
   logic                 w_stall, w_acc_in;
   logic                 w_first, w_last, w_fin;
   logic [TW-1:0]        w_tag2;
   logic signed [SW-1:0] w_sum;
   logic signed [AW-1:0] r_acc, w_acc_nxt;
   logic signed [63:0]   w_rs;
   logic signed [DW-1:0] w_res;
   logic signed [DW-1:0] r_pack [PACK];
   logic [IW-1:0]        r_idx;
   logic                 w_wr, r_flush, r_flush_last;
   logic                 r_out_valid, r_out_last;
   logic [PACK*DW-1:0]   r_out_data, w_pack_flat;

   assign w_stall  = r_out_valid && !out_ready;
   assign w_acc_in = in_valid && (r_state == S_RUN) && !w_stall;
   assign w_first  = (r_beat == '0);
   assign w_last   = (r_beat == r_len - LEN_W'(1));
   assign w_fin    = w_last && (r_neur == r_neurons - LEN_W'(1));

   // job state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next state and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      unique case (r_state)
         S_IDLE:
            if (start && cfg_len != '0)
               w_state_nxt = (cfg_neurons == '0) ? S_DONE : S_RUN;
         S_RUN: begin
            in_ready = !w_stall;
            if (w_acc_in && w_fin) w_state_nxt = S_DRAIN;
         end
         S_DRAIN:
            if (r_out_valid && r_out_last && out_ready)
               w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // config latch, beat/neuron counters, start rejection pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_len     <= '0;
         r_neurons <= '0;
         r_shift   <= '0;
         r_relu    <= 1'b0;
         r_beat    <= '0;
         r_neur    <= '0;
         r_err     <= 1'b0;
      end else begin
         r_err <= (r_state == S_IDLE) && start && (cfg_len == '0);
         if (r_state == S_IDLE && start) begin
            r_len     <= cfg_len;
            r_neurons <= cfg_neurons;
            r_shift   <= cfg_shift;
            r_relu    <= cfg_relu;
            r_beat    <= '0;
            r_neur    <= '0;
         end else if (w_acc_in) begin
            if (w_last) begin
               r_beat <= '0;
               r_neur <= r_neur + LEN_W'(1);
            end else begin
               r_beat <= r_beat + LEN_W'(1);
            end
         end
      end
   end

   mac_lane_tree #(
      .LANES (LANES),
      .DW    (DW),
      .TW    (TW)
   ) u_tree (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (!w_stall),
      .i_tag ({w_acc_in, w_first, w_last, w_fin}),
      .i_ifm (in_ifm),
      .i_w   (in_w),
      .o_sum (w_sum),
      .o_tag (w_tag2)
   );

   // S3 accumulate and post-process the finished neuron
   always_comb begin
      w_acc_nxt = w_tag2[2] ? AW'(w_sum) : r_acc + AW'(w_sum);
      w_rs      = sat_dw(round_shift(64'(w_acc_nxt), r_shift), DW);
      w_res     = (r_relu && w_rs < 0) ? '0 : DW'(w_rs);
      w_wr      = !w_stall && w_tag2[3] && w_tag2[1];
   end

   // accumulator register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                      r_acc <= '0;
      else if (!w_stall && w_tag2[3])  r_acc <= w_acc_nxt;
   end

   // pack slots, slot index and word-complete flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < PACK; p++) r_pack[p] <= '0;
         r_idx        <= '0;
         r_flush      <= 1'b0;
         r_flush_last <= 1'b0;
      end else if (!w_stall) begin
         for (int p = 0; p < PACK; p++) begin
            if (w_wr && r_idx == IW'(p)) r_pack[p] <= w_res;
            else if (r_flush)            r_pack[p] <= '0;
         end
         if (w_wr)
            r_idx <= (r_idx == IW'(PACK-1) || w_tag2[0]) ? '0 : r_idx + IW'(1);
         r_flush      <= w_wr && (r_idx == IW'(PACK-1) || w_tag2[0]);
         r_flush_last <= w_wr && w_tag2[0];
      end
   end

   // flatten pack, slot 0 in the MSBs
   always_comb begin
      w_pack_flat = '0;
      for (int p = 0; p < PACK; p++)
         w_pack_flat[(PACK-1-p)*DW +: DW] = r_pack[p];
   end

   // output word register, held while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_data  <= '0;
      end else if (!w_stall) begin
         r_out_valid <= r_flush;
         r_out_last  <= r_flush && r_flush_last;
         if (r_flush) r_out_data <= w_pack_flat;
      end
   end

   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE);
   assign err       = r_err;
   assign out_valid = r_out_valid;
   assign out_last  = r_out_last;
   assign out_data  = r_out_data;

endmodule

// File: tb/tb_mac_acc_engine.sv
// Directed bench for mac_acc_engine.
// Behavioural dot-product model plus literal word checks.
module tb_mac_acc_engine;

   localparam int LANES = 4;
   localparam int DW    = 16;
   localparam int PACK  = 4;
   localparam int LEN_W = 10;
   localparam int XW    = LANES * DW;
   localparam int OW    = PACK * DW;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic [LEN_W-1:0] cfg_neurons = '0;
   logic [4:0]       cfg_shift = '0;
   logic             cfg_relu = 1'b0;
   logic             busy, done, err;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [XW-1:0]    in_ifm = '0;
   logic [XW-1:0]    in_w = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [OW-1:0]    out_data;
   logic             out_last;

   mac_acc_engine #(
      .LANES(LANES), .DW(DW), .PACK(PACK), .LEN_W(LEN_W), .AW(44)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_len(cfg_len), .cfg_neurons(cfg_neurons),
      .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
      .busy(busy), .done(done), .err(err),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ifm(in_ifm), .in_w(in_w),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [XW-1:0] q_ifm[$];
   logic [XW-1:0] q_w[$];
   logic [OW-1:0] exp_d[$];
   bit            exp_l[$];
   logic [OW:0]   rx[$];

   int            acc_cyc = 0, rise_cyc = 0, hs_cyc = 0;
   bit            prev_v = 0, prev_stall = 0, prev_l = 0, ov_seen = 0;
   logic [OW-1:0] prev_d = '0;

   task automatic chk(input string nm, input logic [127:0] got,
                      input logic [127:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, got, want);
      end
   endtask

   task automatic chk_rx(input string nm, input int i,
                         input logic [OW:0] want);
      if (i >= rx.size()) begin
         checks++;
         errors++;
         $display("FAIL %s got=missing want=%0h", nm, want);
      end else begin
         chk(nm, rx[i], want);
      end
   endtask

   // spec rule: round half up by floor division, saturate, ReLU
   function automatic logic [DW-1:0] post(input longint s, input int sh,
                                          input bit relu);
      longint r, d;
      r = s;
      if (sh > 0) begin
         d = longint'(1) << sh;
         r = s + d / 2;
         if (r >= 0) r = r / d;
         else        r = -((-r + d - 1) / d);
      end
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return r[DW-1:0];
   endfunction

   task automatic model_job(input int len, input int nrn, input int sh,
                            input bit relu);
      logic [OW-1:0] w;
      logic [XW-1:0] a, c;
      longint        s;
      int            slot;
      w    = '0;
      slot = 0;
      for (int n = 0; n < nrn; n++) begin
         s = 0;
         for (int b = 0; b < len; b++) begin
            a = q_ifm[n*len+b];
            c = q_w[n*len+b];
            for (int l = 0; l < LANES; l++)
               s += longint'($signed(a[(LANES-1-l)*DW +: DW]))
                  * longint'($signed(c[(LANES-1-l)*DW +: DW]));
         end
         w[(PACK-1-slot)*DW +: DW] = post(s, sh, relu);
         slot++;
         if (slot == PACK || n == nrn - 1) begin
            exp_d.push_back(w);
            exp_l.push_back(n == nrn - 1);
            w    = '0;
            slot = 0;
         end
      end
   endtask

   // compare process: every handshake, stall hold, stall backpressure
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) acc_cyc = cyc;
         if (out_valid && !prev_v) rise_cyc = cyc;
         if (out_valid) ov_seen = 1;
         if (prev_stall)
            chk("stall_hold", {out_valid, out_last, out_data},
                {1'b1, prev_l, prev_d});
         if (out_valid && !out_ready)
            chk("stall_in_ready", in_ready, 0);
         if (out_valid && out_ready) begin
            hs_cyc = cyc;
            rx.push_back({out_last, out_data});
            if (exp_d.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word got=%0h want=none", out_data);
            end else begin
               chk("word_data", out_data, exp_d.pop_front());
               chk("word_last", out_last, exp_l.pop_front());
            end
         end
         prev_v     = out_valid;
         prev_stall = out_valid && !out_ready;
         prev_d     = out_data;
         prev_l     = out_last;
      end else begin
         prev_v     = 0;
         prev_stall = 0;
      end
   end

   task automatic fill_const(input int nb, input logic [DW-1:0] a,
                             input logic [DW-1:0] b);
      q_ifm.delete();
      q_w.delete();
      for (int i = 0; i < nb; i++) begin
         q_ifm.push_back({LANES{a}});
         q_w.push_back({LANES{b}});
      end
   endtask

   task automatic push_lane0(input logic [DW-1:0] a, input logic [DW-1:0] b);
      logic [XW-1:0] x, y;
      x = '0;
      y = '0;
      x[XW-1 -: DW] = a;
      y[XW-1 -: DW] = b;
      q_ifm.push_back(x);
      q_w.push_back(y);
   endtask

   task automatic start_job(input int len, input int nrn, input int sh,
                            input bit relu);
      start       = 1'b1;
      cfg_len     = LEN_W'(len);
      cfg_neurons = LEN_W'(nrn);
      cfg_shift   = 5'(sh);
      cfg_relu    = relu;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic feed(input int nb);
      bit ok;
      for (int b = 0; b < nb; b++) begin
         ok       = 0;
         in_valid = 1'b1;
         in_ifm   = q_ifm[b];
         in_w     = q_w[b];
         for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
         end
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL feed_timeout got=beat%0d want=accepted", b);
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done(input bit timed);
      bit seen;
      seen = 0;
      for (int t = 0; t < 400 && !seen; t++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            if (timed) chk("done_after_hs", 128'(cyc - hs_cyc), 128'd1);
         end
      end
      chk("done_seen", seen, 1);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_job(input int len, input int nrn, input int sh,
                         input bit relu);
      rx.delete();
      model_job(len, nrn, sh, relu);
      start_job(len, nrn, sh, relu);
      feed(len * nrn);
      wait_done(1);
      chk("all_words_out", exp_d.size(), 0);
   endtask

   int errs, busys;

   initial begin
      #1;
      chk("reset_outs",
          {busy, done, err, in_ready, out_valid, out_last, out_data}, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic: 2 beats x 4 lanes x (1*2) = 16 per neuron
      fill_const(8, 16'd1, 16'd2);
      model_job(2, 4, 0, 0);
      chk("model_basic", exp_d[0], 64'h0010_0010_0010_0010);
      exp_d.delete();
      exp_l.delete();
      do_job(2, 4, 0, 0);
      chk_rx("basic_word", 0, 65'h1_0010_0010_0010_0010);
      chk("basic_latency", 128'(rise_cyc - acc_cyc), 128'd4);

      // saturation and ReLU
      fill_const(4, 16'h7FFF, 16'h7FFF);
      do_job(4, 1, 0, 0);
      chk_rx("sat_pos", 0, 65'h1_7FFF_0000_0000_0000);
      fill_const(4, 16'h7FFF, 16'h8000);
      do_job(4, 1, 0, 1);
      chk_rx("relu_neg", 0, 65'h1_0000_0000_0000_0000);
      do_job(4, 1, 0, 0);
      chk_rx("sat_neg", 0, 65'h1_8000_0000_0000_0000);

      // rounding with shift 4: 24 -> 2, -24 -> -1, 7 -> 0
      q_ifm.delete();
      q_w.delete();
      push_lane0(16'd24, 16'd1);
      push_lane0(16'hFFE8, 16'd1);
      push_lane0(16'd7, 16'd1);
      model_job(1, 3, 4, 0);
      chk("model_round", exp_d[0], 64'h0002_FFFF_0000_0000);
      exp_d.delete();
      exp_l.delete();
      do_job(1, 3, 4, 0);
      chk_rx("round_word", 0, 65'h1_0002_FFFF_0000_0000);

      // partial word and 10-cycle backpressure; neuron k sums 12*(k+1)
      q_ifm.delete();
      q_w.delete();
      for (int k = 0; k < 5; k++)
         for (int b = 0; b < 4; b++) push_lane0(16'(k + 1), 16'd3);
      rx.delete();
      model_job(4, 5, 0, 0);
      out_ready = 1'b0;
      start_job(4, 5, 0, 0);
      fork
         feed(20);
         begin
            for (int t = 0; t < 300 && !out_valid; t++) begin
               @(posedge clk);
               #1;
            end
            repeat (10) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      wait_done(1);
      chk("bp_all_out", exp_d.size(), 0);
      chk_rx("bp_word0", 0, 65'h0_000C_0018_0024_0030);
      chk_rx("bp_word1", 1, 65'h1_003C_0000_0000_0000);

      // cfg_len == 0: err pulse, never busy
      errs  = 0;
      busys = 0;
      start_job(0, 3, 0, 0);
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         if (err)  errs++;
         if (busy) busys++;
      end
      chk("len0_err", errs, 1);
      chk("len0_busy", busys, 0);
      @(posedge clk);
      #1;

      // cfg_neurons == 0: done without output
      ov_seen = 0;
      start_job(3, 0, 0, 0);
      wait_done(0);
      chk("nrn0_no_out", ov_seen, 0);

      // reset mid-job, then a fresh job
      fill_const(16, 16'd5, 16'd5);
      start_job(4, 4, 0, 0);
      feed(3);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_outs",
          {busy, done, err, in_ready, out_valid, out_last, out_data}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      fill_const(8, 16'd3, 16'hFFFF);
      do_job(2, 4, 0, 0);
      chk_rx("post_rst_word", 0, 65'h1_FFE8_FFE8_FFE8_FFE8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mac_acc_engine.md
Name: mac_acc_engine

Overview:
Parametrised successor to the fixed 4-lane 16-bit MAC/accumulator/pack path in the CNN datapath. Takes LANES ifm/weight pairs per beat and forms one dot product per neuron over cfg_len beats. Each result is rounded, shifted, optionally ReLU'd and saturated, then packed PACK results per output word. Sits between the ifm/weight buffers and the output buffer, with valid/ready handshakes on both sides and a start/done job interface.

Parameters:
LANES, 4, multiply lanes per beat (power of 2)
DW, 16, signed ifm/weight/result width
PACK, 4, results per output word
LEN_W, 10, width of cfg_len and cfg_neurons
AW, 44, accumulator width (>= 2*DW+clog2(LANES)+LEN_W)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  job start pulse, sampled in IDLE only
cfg_len  in  LEN_W  beats per neuron
cfg_neurons  in  LEN_W  neurons per job
cfg_shift  in  5  arithmetic right shift applied to each result
cfg_relu  in  1  clamp negative results to 0
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at job end
err  out  1  one-cycle pulse when start is rejected
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid&&in_ready
in_ifm  in  LANES*DW  lane 0 in MSBs
in_w  in  LANES*DW  lane 0 in MSBs
out_valid  out  1  output word valid
out_ready  in  1  downstream accept
out_data  out  PACK*DW  slot 0 in MSBs
out_last  out  1  final word of job

Behaviour:
- Reset: all outputs 0, state IDLE, counters, pack and pipeline cleared. Reset mid-job aborts the job with no done pulse.
- States:
  - IDLE: start latches cfg_*. If cfg_len==0, pulse err and stay IDLE. If cfg_neurons==0, go to DONE. Otherwise go to RUN.
  - RUN: in_ready = !stall; count beats and neurons. When the last beat of the last neuron is accepted, go to DRAIN.
  - DRAIN: in_ready=0; wait for the pipeline to empty and the final word to be accepted, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- stall = out_valid && !out_ready. A stall freezes every pipeline stage and the pack register.
- Pipeline, 3 stages:
  - S1 registers LANES signed DWxDW products.
  - S2 registers the adder-tree sum with first/last-of-neuron flags.
  - S3: on first, acc loads the sum; otherwise acc += sum. AW two's complement, wraps.
- Post-process on last: if shift>0, add 1<<(shift-1), then >>> shift. Saturate to [-2^(DW-1), 2^(DW-1)-1]. If relu and negative, 0. Write to pack slot idx.
- Output: when slot PACK-1 is written, or the job's final result is written, copy the pack to out_data. Unused slots are zero. Set out_valid, set out_last on the final word, reset idx to 0.
- out_data and out_last hold while out_valid && !out_ready. out_valid clears on handshake unless a new word loads in the same cycle.
- Latency: out_valid rises 4 cycles after the handshake of the beat that completes a word, with no stall.
- Beats arriving while in_ready=0 are ignored. start outside IDLE is ignored.

Decomposition:
- Shared package cnn_pkg: state enum (IDLE/RUN/DRAIN/DONE), sat_dw and round_shift functions, clog2 constant helper.
- Sub-module mac_lane_tree (parameters LANES, DW): S1 product registers plus registered adder tree, with an enable input for stall.

Test Plan:
- Basic: len=2, neurons=4, shift=0, all ifm=1, w=2 -> one word {16,16,16,16}, out_last=1, done pulses one cycle after handshake.
- Saturation/ReLU: ifm=w=0x7FFF, len=4 -> 0x7FFF. ifm=0x7FFF, w=0x8000, relu=1 -> 0x0000. Same with relu=0 -> 0x8000.
- Rounding: shift=4, neuron sum 24 -> 2. Sum -24 -> -1. Sum 7 -> 0.
- Partial word and backpressure:
  - neurons=5 -> word0 has 4 results, out_last=0. Word1 = {r4,0,0,0}, out_last=1.
  - Hold out_ready=0 for 10 cycles -> in_ready=0, out_data stable, no result lost.
- Config errors: start with cfg_len=0 -> err pulse, busy stays 0. cfg_neurons=0 -> done pulse, no out_valid.
- Reset mid-job: drop rst_n during RUN -> all outputs 0 immediately. A new job afterwards produces correct results with no stale accumulation.
